// File: rtl/wav_i2s_tx.sv
// I2S transmitter for 16-bit PCM playback to a WM8731 in master mode.
// BCLK/LRCK come from the codec and are oversampled by clk_50M. One read strobe
// is issued per channel slot. Each word is shifted out MSB first, starting one
// BCLK after the LRCK edge.
module wav_i2s_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              en,
  input  logic              dac_bclk,
  input  logic              dac_lrck,
  output logic              wav_rden,
  input  logic [DATA_W-1:0] wav_data,
  output logic              dac_dat,
  output logic              frame_tick,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BC_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic                   r_bclk_hist;
  logic                   r_lrck_hist;
  logic                   w_bclk_cur;
  logic                   w_lrck_cur;
  logic                   w_bclk_fall;
  logic                   w_lrck_edge;
  logic                   w_lrck_fall;

  logic [DATA_W-1:0]      r_shift;
  logic [BC_W-1:0]        r_bit_cnt;
  logic                   r_rden;
  logic                   r_dat;
  logic                   r_tick;
  logic [CNT_W-1:0]       r_frame_cnt;

  // Both codec clocks use identical sync depth, so their edge alignment survives.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_bclk_hist <= 1'b0;
      r_lrck_hist <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], dac_bclk};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], dac_lrck};
      r_bclk_hist <= w_bclk_cur;
      r_lrck_hist <= w_lrck_cur;
    end
  end

  assign w_bclk_cur  = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrck_cur  = r_lrck_sync[SYNC_STAGES-1];
  assign w_bclk_fall = r_bclk_hist & ~w_bclk_cur;
  assign w_lrck_edge = r_lrck_hist ^ w_lrck_cur;
  assign w_lrck_fall = r_lrck_hist & ~w_lrck_cur;

  // State register.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; en only matters in IDLE and at slot boundaries.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_ARM;
      S_ARM:   if (w_lrck_fall) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_lrck_edge) w_state_nxt = en ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: read strobe, word load, serial shift and frame counting.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_rden      <= 1'b0;
      r_dat       <= 1'b0;
      r_tick      <= 1'b0;
      r_frame_cnt <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_tick <= 1'b0;
      // Registered from next state so the strobe is high exactly while in REQ.
      r_rden <= (w_state_nxt == S_REQ);
      case (r_state)
        S_IDLE, S_ARM: r_dat <= 1'b0;
        S_LOAD: begin
          r_shift   <= wav_data;
          r_bit_cnt <= BC_W'(DATA_W);
          if (w_lrck_cur) begin
            r_tick      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (w_lrck_edge) begin
            // Slot boundary: drop any unsent bits; the coincident BCLK fall sends nothing.
            if (w_bclk_fall) r_dat <= 1'b0;
          end else if (w_bclk_fall) begin
            if (r_bit_cnt != '0) begin
              r_dat     <= r_shift[DATA_W-1];
              r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end else begin
              r_dat <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign wav_rden   = r_rden;
  assign dac_dat    = r_dat;
  assign frame_tick = r_tick;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_wav_i2s_tx.sv
// Bench for wav_i2s_tx: a codec model generates BCLK/LRCK and captures dac_dat on
// BCLK rises, a buffer model answers read strobes with random or fixed words, and
// each slot is checked against the expected I2S bit pattern.
`timescale 1ns/100ps
module tb_wav_i2s_tx;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned NS   = 1024;
  localparam int unsigned HALF = 163;

  logic          clk_50M = 1'b0;
  logic          rst;
  logic          en;
  logic          dac_bclk;
  logic          dac_lrck;
  logic          wav_rden;
  logic [DW-1:0] wav_data;
  logic          dac_dat;
  logic          frame_tick;
  logic [CW-1:0] frame_cnt;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  wav_i2s_tx #(
    .SYNC_STAGES(SYNC),
    .DATA_W     (DW),
    .CNT_W      (CW)
  ) dut (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .en        (en),
    .dac_bclk  (dac_bclk),
    .dac_lrck  (dac_lrck),
    .wav_rden  (wav_rden),
    .wav_data  (wav_data),
    .dac_dat   (dac_dat),
    .frame_tick(frame_tick),
    .frame_cnt (frame_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  int unsigned pos_count = 0;
  always @(posedge clk_50M) pos_count <= pos_count + 1;

  // Codec-side records (written by the codec model only).
  int unsigned slot_len = 32;
  int unsigned slot_idx = 0;
  int unsigned edge_cyc = 0;
  logic [63:0] cap    [NS];
  int unsigned slen   [NS];
  logic        slot_ch[NS];

  // Buffer-side records (written by the buffer model only).
  int unsigned   rd_cnt [NS];
  int unsigned   rd_lat [NS];
  logic [DW-1:0] rd_word[NS];
  int unsigned   rd_total = 0;
  int unsigned   right_rd = 0;
  int unsigned   tick_cnt = 0;
  logic [DW-1:0] fixed_q[$];

  int unsigned right_base = 0;
  int unsigned tick_base  = 0;

  // Codec model: BCLK half period off the 50 MHz grid; LRCK toggles on BCLK fall.
  initial begin
    dac_bclk   = 1'b1;
    dac_lrck   = 1'b1;
    cap[0]     = '0;
    slen[0]    = 0;
    slot_ch[0] = 1'b1;
    #0.5;
    forever begin
      for (int unsigned b = 0; b < slot_len; b++) begin
        dac_bclk = 1'b0;
        if (b == 0) begin
          dac_lrck = ~dac_lrck;
          edge_cyc = pos_count;
          cap[(slot_idx + 1) % NS]     = '0;
          slen[(slot_idx + 1) % NS]    = 0;
          slot_ch[(slot_idx + 1) % NS] = dac_lrck;
          slot_idx = slot_idx + 1;
        end
        #HALF;
        dac_bclk = 1'b1;
        cap[slot_idx % NS][b] = dac_dat;
        slen[slot_idx % NS]   = b + 1;
        #HALF;
      end
    end
  end

  // Buffer model: word appears one cycle after the strobe and holds until the next.
  initial begin
    int unsigned   mon_slot;
    bit            pend;
    logic [DW-1:0] pend_w;
    logic [DW-1:0] w;
    mon_slot = 0;
    pend     = 1'b0;
    pend_w   = '0;
    wav_data = '0;
    rd_cnt[0] = 0;
    forever begin
      @(negedge clk_50M);
      if (slot_idx != mon_slot) begin
        mon_slot = slot_idx;
        rd_cnt[mon_slot % NS]  = 0;
        rd_lat[mon_slot % NS]  = 0;
        rd_word[mon_slot % NS] = '0;
      end
      if (pend) begin
        wav_data = pend_w;
        pend     = 1'b0;
      end
      if (wav_rden) begin
        if (fixed_q.size() > 0) w = fixed_q.pop_front();
        else                    w = DW'($urandom);
        rd_cnt[mon_slot % NS] = rd_cnt[mon_slot % NS] + 1;
        if (rd_cnt[mon_slot % NS] == 1) begin
          rd_lat[mon_slot % NS]  = pos_count - edge_cyc;
          rd_word[mon_slot % NS] = w;
        end
        if (slot_ch[mon_slot % NS]) right_rd = right_rd + 1;
        rd_total = rd_total + 1;
        pend     = 1'b1;
        pend_w   = w;
      end
      if (frame_tick) tick_cnt = tick_cnt + 1;
    end
  end

  // Reference: bit b of a slot (sampled on the b-th BCLK rise) carries the word's
  // bit DW-b for b = 1..DW; the edge bit and padding are 0; nothing without a read.
  function automatic logic [63:0] exp_bits(input int unsigned s);
    logic [63:0]   e;
    logic [DW-1:0] w;
    int unsigned   i;
    e = '0;
    i = s % NS;
    w = rd_word[i];
    if (rd_cnt[i] == 1)
      for (int unsigned b = 1; b < slen[i] && b <= DW; b++) e[b] = w[DW-b];
    return e;
  endfunction

  function automatic logic [CW-1:0] exp_frames();
    return CW'(right_rd - right_base);
  endfunction

  // Waits for the next slot start of a channel (0 left, 1 right, 2 any).
  task automatic wait_slot(input int want_ch);
    int unsigned s0;
    int unsigned g;
    bit          done;
    s0   = slot_idx;
    g    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk_50M);
      g++;
      if (slot_idx != s0) begin
        if (want_ch == 2 || slot_ch[slot_idx % NS] == 1'(want_ch)) done = 1'b1;
        s0 = slot_idx;
      end
      if (!done && g > 4000) begin
        vectors++;
        miscompares++;
        $display("FAIL slot_wait timeout: got no slot start, want channel %0d", want_ch);
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    int unsigned s0;
    int unsigned rd0;
    rst = 1'b1;
    en  = 1'b0;
    repeat (4) @(negedge clk_50M);
    vectors++; if (dac_dat !== 1'b0)  begin miscompares++; $display("FAIL reset_dat got %b want 0", dac_dat); end
    vectors++; if (wav_rden !== 1'b0) begin miscompares++; $display("FAIL reset_rden got %b want 0", wav_rden); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    vectors++; if (frame_cnt !== '0)  begin miscompares++; $display("FAIL reset_cnt got %0d want 0", frame_cnt); end
    rst = 1'b0;
    right_base = right_rd;
    tick_base  = tick_cnt;
    rd0 = rd_total;
    wait_slot(2);
    s0 = slot_idx;
    repeat (4) wait_slot(2);
    vectors++; if (rd_total != rd0) begin miscompares++; $display("FAIL idle_rden got %0d strobes want 0", rd_total - rd0); end
    for (int unsigned s = s0; s < slot_idx; s++) begin
      vectors++;
      if (cap[s % NS] !== 64'd0) begin miscompares++; $display("FAIL idle_dat slot %0d got %h want 0", s, cap[s % NS]); end
    end
    vectors++; if (frame_cnt !== '0) begin miscompares++; $display("FAIL idle_cnt got %0d want 0", frame_cnt); end
  endtask

  task automatic test_basic();
    int unsigned sr;
    int unsigned sl;
    int unsigned sR;
    fixed_q.push_back(16'hA5C3);
    fixed_q.push_back(16'h0F01);
    wait_slot(1);
    #(HALF * 20);
    en = 1'b1;
    sr = slot_idx;
    wait_slot(0);
    sl = slot_idx;
    wait_slot(1);
    sR = slot_idx;
    wait_slot(0);
    vectors++; if (rd_cnt[sr % NS] != 0) begin miscompares++; $display("FAIL start_early_rden got %0d want 0", rd_cnt[sr % NS]); end
    vectors++; if (rd_cnt[sl % NS] != 1) begin miscompares++; $display("FAIL start_left_rden got %0d want 1", rd_cnt[sl % NS]); end
    vectors++; if (rd_lat[sl % NS] != SYNC + 1) begin miscompares++; $display("FAIL start_latency got %0d want %0d", rd_lat[sl % NS], SYNC + 1); end
    vectors++; if (rd_word[sl % NS] !== 16'hA5C3) begin miscompares++; $display("FAIL basic_left_word got %h want a5c3", rd_word[sl % NS]); end
    vectors++; if (cap[sl % NS] !== exp_bits(sl)) begin miscompares++; $display("FAIL basic_left_bits got %h want %h", cap[sl % NS], exp_bits(sl)); end
    vectors++; if (rd_word[sR % NS] !== 16'h0F01) begin miscompares++; $display("FAIL basic_right_word got %h want 0f01", rd_word[sR % NS]); end
    vectors++; if (cap[sR % NS] !== exp_bits(sR)) begin miscompares++; $display("FAIL basic_right_bits got %h want %h", cap[sR % NS], exp_bits(sR)); end
    vectors++; if (frame_cnt !== 4'd1) begin miscompares++; $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); end
    vectors++; if (tick_cnt - tick_base != 1) begin miscompares++; $display("FAIL basic_frame_tick got %0d want 1", tick_cnt - tick_base); end
  endtask

  task automatic test_stream();
    int unsigned s0;
    s0 = slot_idx;
    repeat (8) wait_slot(2);
    for (int unsigned s = s0; s < slot_idx; s++) begin
      vectors++;
      if (rd_cnt[s % NS] != 1) begin miscompares++; $display("FAIL stream_rden slot %0d got %0d want 1", s, rd_cnt[s % NS]); end
      vectors++;
      if (cap[s % NS] !== exp_bits(s)) begin miscompares++; $display("FAIL stream_bits slot %0d got %h want %h", s, cap[s % NS], exp_bits(s)); end
      vectors++;
      if (rd_lat[s % NS] != SYNC + 1) begin miscompares++; $display("FAIL stream_latency slot %0d got %0d want %0d", s, rd_lat[s % NS], SYNC + 1); end
    end
    vectors++; if (frame_cnt !== exp_frames()) begin miscompares++; $display("FAIL stream_cnt got %0d want %0d", frame_cnt, exp_frames()); end
    vectors++; if (tick_cnt - tick_base != right_rd - right_base) begin miscompares++; $display("FAIL stream_ticks got %0d want %0d", tick_cnt - tick_base, right_rd - right_base); end
  endtask

  task automatic test_short_slot();
    int unsigned s0;
    wait_slot(2);
    slot_len = 12;
    s0 = slot_idx;
    repeat (6) wait_slot(2);
    slot_len = 32;
    for (int unsigned s = s0; s < s0 + 6; s++) begin
      vectors++;
      if (rd_cnt[s % NS] != 1) begin miscompares++; $display("FAIL short_rden slot %0d got %0d want 1", s, rd_cnt[s % NS]); end
      vectors++;
      if (cap[s % NS] !== exp_bits(s)) begin miscompares++; $display("FAIL short_bits slot %0d got %h want %h", s, cap[s % NS], exp_bits(s)); end
    end
  endtask

  task automatic test_disable();
    int unsigned sL;
    wait_slot(0);
    #(HALF * 7);
    en = 1'b0;
    sL = slot_idx;
    repeat (3) wait_slot(2);
    vectors++; if (rd_cnt[sL % NS] != 1) begin miscompares++; $display("FAIL disable_last_rden got %0d want 1", rd_cnt[sL % NS]); end
    vectors++; if (cap[sL % NS] !== exp_bits(sL)) begin miscompares++; $display("FAIL disable_last_bits got %h want %h", cap[sL % NS], exp_bits(sL)); end
    for (int unsigned s = sL + 1; s < sL + 3; s++) begin
      vectors++;
      if (rd_cnt[s % NS] != 0) begin miscompares++; $display("FAIL disable_rden slot %0d got %0d want 0", s, rd_cnt[s % NS]); end
      vectors++;
      if (cap[s % NS] !== 64'd0) begin miscompares++; $display("FAIL disable_dat slot %0d got %h want 0", s, cap[s % NS]); end
    end
    vectors++; if (frame_cnt !== exp_frames()) begin miscompares++; $display("FAIL disable_cnt got %0d want %0d", frame_cnt, exp_frames()); end
  endtask

  task automatic test_reset_mid();
    int unsigned rs;
    int unsigned s2;
    fixed_q.push_back(16'hFFFF);
    wait_slot(1);
    #(HALF * 10);
    en = 1'b1;
    wait_slot(0);
    #(HALF * 9);
    vectors++; if (dac_dat !== 1'b1) begin miscompares++; $display("FAIL midword_dat got %b want 1", dac_dat); end
    @(negedge clk_50M);
    rst = 1'b1;
    #1;
    vectors++; if (dac_dat !== 1'b0) begin miscompares++; $display("FAIL rst_async_dat got %b want 0", dac_dat); end
    @(posedge clk_50M);
    #1;
    vectors++; if (dac_dat !== 1'b0)    begin miscompares++; $display("FAIL rst_dat got %b want 0", dac_dat); end
    vectors++; if (wav_rden !== 1'b0)   begin miscompares++; $display("FAIL rst_rden got %b want 0", wav_rden); end
    vectors++; if (frame_cnt !== '0)    begin miscompares++; $display("FAIL rst_cnt got %0d want 0", frame_cnt); end
    repeat (3) @(negedge clk_50M);
    rst = 1'b0;
    right_base = right_rd;
    tick_base  = tick_cnt;
    rs = slot_idx;
    wait_slot(1);
    wait_slot(0);
    s2 = slot_idx;
    wait_slot(1);
    vectors++; if (rd_cnt[(rs + 1) % NS] != 0) begin miscompares++; $display("FAIL rst_rearm_rden got %0d want 0", rd_cnt[(rs + 1) % NS]); end
    vectors++; if (cap[(rs + 1) % NS] !== 64'd0) begin miscompares++; $display("FAIL rst_rearm_dat got %h want 0", cap[(rs + 1) % NS]); end
    vectors++; if (rd_cnt[s2 % NS] != 1) begin miscompares++; $display("FAIL rst_restart_rden got %0d want 1", rd_cnt[s2 % NS]); end
    vectors++; if (cap[s2 % NS] !== exp_bits(s2)) begin miscompares++; $display("FAIL rst_restart_bits got %h want %h", cap[s2 % NS], exp_bits(s2)); end
  endtask

  task automatic test_wrap();
    int unsigned g;
    g = 0;
    while (right_rd - right_base < 17 && g < 40000) begin
      @(negedge clk_50M);
      g++;
    end
    vectors++; if (right_rd - right_base < 17) begin miscompares++; $display("FAIL wrap_timeout got %0d frames want 17", right_rd - right_base); end
    repeat (10) @(negedge clk_50M);
    vectors++; if (frame_cnt !== 4'd1) begin miscompares++; $display("FAIL wrap_cnt got %0d want 1", frame_cnt); end
    vectors++; if (frame_cnt !== exp_frames()) begin miscompares++; $display("FAIL wrap_model got %0d want %0d", frame_cnt, exp_frames()); end
    vectors++; if (tick_cnt - tick_base != 17) begin miscompares++; $display("FAIL wrap_ticks got %0d want 17", tick_cnt - tick_base); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_short_slot();
    test_disable();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
